// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide execution unit that owns the HI/LO pair.
// Runs one operation at a time and returns a tagged result. HI/LO only
// change when that result is handed off to the consumer.
//
// Ports
//   clk, rst       clock and async active-low reset
//   flush          sync flush; drops the op in flight and its HI/LO update
//   in_valid/in_ready, in_funct, in_op_a, in_op_b, in_tag   issue side
//   out_valid/out_ready, out_data, out_wen, out_tag         result side
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing in flight; ready to accept
// MUL   | one cycle to form product / multiply-accumulate
// DIV   | 32 restoring-division steps on operand magnitudes
// FIX   | apply quotient/remainder signs
// DONE  | result presented; waits for out_ready (may accept next op)
module mul_div_unit #(
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_funct,
  input  logic [31:0]          in_op_a,
  input  logic [31:0]          in_op_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_wen,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam logic [5:0] FUNCT_MFHI   = 6'h10;
  localparam logic [5:0] FUNCT_MTHI   = 6'h11;
  localparam logic [5:0] FUNCT_MFLO   = 6'h12;
  localparam logic [5:0] FUNCT_MTLO   = 6'h13;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
  localparam logic [5:0] FUNCT2_MADD  = 6'h00;
  localparam logic [5:0] FUNCT2_MADDU = 6'h01;
  localparam logic [5:0] FUNCT2_MUL   = 6'h02;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h04;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h05;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           r_state;
  logic [5:0]           r_funct;
  logic [TAG_WIDTH-1:0] r_tag;
  // Multiply: raw operands. Divide: r_a is dividend shifting out / quotient
  // shifting in, r_b is the divisor magnitude.
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_rem;
  logic [4:0]           r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic [31:0]          r_res_hi;
  logic [31:0]          r_res_lo;
  logic                 r_hi_wen;
  logic                 r_lo_wen;
  logic [31:0]          r_out_data;
  logic                 r_out_wen;

  logic        w_accept;
  logic        w_hs;
  logic [31:0] w_hi_fwd;
  logic [31:0] w_lo_fwd;
  logic        w_in_mul;
  logic        w_in_div;
  logic        w_in_sdiv;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_mul_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [63:0] w_acc;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_new_rem;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign out_valid = (r_state == S_DONE);
  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_data  = r_out_data;
  assign out_wen   = r_out_wen;
  assign out_tag   = r_tag;

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_hs     = out_valid & out_ready & ~flush;

  // A move-from accepted on the same edge as a HI/LO commit sees the new value.
  assign w_hi_fwd = (w_hs & r_hi_wen) ? r_res_hi : r_hi;
  assign w_lo_fwd = (w_hs & r_lo_wen) ? r_res_lo : r_lo;

  assign w_in_mul = (in_funct == FUNCT_MULT)  | (in_funct == FUNCT_MULTU) |
                    (in_funct == FUNCT2_MUL)  | (in_funct == FUNCT2_MADD) |
                    (in_funct == FUNCT2_MADDU) | (in_funct == FUNCT2_MSUB) |
                    (in_funct == FUNCT2_MSUBU);
  assign w_in_div  = (in_funct == FUNCT_DIV) | (in_funct == FUNCT_DIVU);
  assign w_in_sdiv = (in_funct == FUNCT_DIV);
  assign w_abs_a   = (w_in_sdiv & in_op_a[31]) ? -in_op_a : in_op_a;
  assign w_abs_b   = (w_in_sdiv & in_op_b[31]) ? -in_op_b : in_op_b;

  // Low 64 bits of the product of the sign/zero-extended operands are the
  // correct signed or unsigned 64-bit result.
  assign w_mul_sgn = (r_funct == FUNCT_MULT) | (r_funct == FUNCT2_MUL) |
                     (r_funct == FUNCT2_MADD) | (r_funct == FUNCT2_MSUB);
  assign w_a64  = {{32{w_mul_sgn & r_a[31]}}, r_a};
  assign w_b64  = {{32{w_mul_sgn & r_b[31]}}, r_b};
  assign w_prod = w_a64 * w_b64;
  assign w_acc  = {r_hi, r_lo};

  // With a zero divisor every step subtracts nothing: quotient all ones and
  // the remainder ends up holding the dividend magnitude.
  assign w_rem_sh  = {r_rem, r_a[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_sub     = w_rem_sh[31:0] - r_b;
  assign w_new_rem = w_ge ? w_sub : w_rem_sh[31:0];

  assign w_q_fix = r_neg_q ? -r_a : r_a;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_funct    <= '0;
      r_tag      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_hi_wen   <= 1'b0;
      r_lo_wen   <= 1'b0;
      r_out_data <= '0;
      r_out_wen  <= 1'b0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_hi_wen   <= 1'b0;
      r_lo_wen   <= 1'b0;
      r_out_data <= '0;
      r_out_wen  <= 1'b0;
    end else begin
      if (w_hs) begin
        if (r_hi_wen) r_hi <= r_res_hi;
        if (r_lo_wen) r_lo <= r_res_lo;
        r_state    <= S_IDLE;
        r_hi_wen   <= 1'b0;
        r_lo_wen   <= 1'b0;
        r_out_data <= '0;
        r_out_wen  <= 1'b0;
      end

      case (r_state)
        S_MUL: begin
          r_state <= S_DONE;
          if (r_funct == FUNCT2_MUL) begin
            r_out_data <= w_prod[31:0];
            r_out_wen  <= 1'b1;
          end else begin
            r_hi_wen <= 1'b1;
            r_lo_wen <= 1'b1;
            if ((r_funct == FUNCT2_MADD) | (r_funct == FUNCT2_MADDU))
              {r_res_hi, r_res_lo} <= w_acc + w_prod;
            else if ((r_funct == FUNCT2_MSUB) | (r_funct == FUNCT2_MSUBU))
              {r_res_hi, r_res_lo} <= w_acc - w_prod;
            else
              {r_res_hi, r_res_lo} <= w_prod;
          end
        end
        S_DIV: begin
          r_a   <= {r_a[30:0], w_ge};
          r_rem <= w_new_rem;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state  <= S_DONE;
          r_res_lo <= w_q_fix;
          r_res_hi <= w_r_fix;
          r_hi_wen <= 1'b1;
          r_lo_wen <= 1'b1;
        end
        default: ;
      endcase

      if (w_accept) begin
        r_funct    <= in_funct;
        r_tag      <= in_tag;
        r_hi_wen   <= 1'b0;
        r_lo_wen   <= 1'b0;
        r_out_data <= '0;
        r_out_wen  <= 1'b0;
        if (w_in_mul) begin
          r_state <= S_MUL;
          r_a     <= in_op_a;
          r_b     <= in_op_b;
        end else if (w_in_div) begin
          r_state <= S_DIV;
          r_a     <= w_abs_a;
          r_b     <= w_abs_b;
          r_rem   <= '0;
          r_cnt   <= 5'd31;
          r_neg_q <= w_in_sdiv & (in_op_a[31] ^ in_op_b[31]);
          r_neg_r <= w_in_sdiv & in_op_a[31];
        end else begin
          r_state <= S_DONE;
          if (in_funct == FUNCT_MFHI) begin
            r_out_data <= w_hi_fwd;
            r_out_wen  <= 1'b1;
          end else if (in_funct == FUNCT_MFLO) begin
            r_out_data <= w_lo_fwd;
            r_out_wen  <= 1'b1;
          end else if (in_funct == FUNCT_MTHI) begin
            r_res_hi <= in_op_a;
            r_hi_wen <= 1'b1;
          end else if (in_funct == FUNCT_MTLO) begin
            r_res_lo <= in_op_a;
            r_lo_wen <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes the expected result
// of every issued op into a queue; a negedge monitor checks latency, hold
// behaviour and the handed-off result against the queue head.
module tb_mul_div_unit;
  localparam int TW = 6;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;
  localparam logic [32:0] NOWANT = 33'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0] in_funct = '0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  logic out_wen;
  logic [TW-1:0] out_tag;

  mul_div_unit #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wen(out_wen), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   data;
    logic          wen;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int rdy_mode = 1;
  logic [TW-1:0] next_tag = '0;
  bit seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural reference: HI/LO updated in issue order, results from
  // plain 64-bit arithmetic and integer division on magnitudes.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic w, output int lat);
    logic [63:0] acc, sp, up;
    logic [31:0] ma, mb, qq, rr;
    bit s;
    d = '0; w = 1'b0; lat = 1;
    acc = {m_hi, m_lo};
    sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    up = {32'b0, a} * {32'b0, b};
    case (f)
      F_MULT:  begin {m_hi, m_lo} = sp; lat = 2; end
      F_MULTU: begin {m_hi, m_lo} = up; lat = 2; end
      F_MUL:   begin d = sp[31:0]; w = 1'b1; lat = 2; end
      F_MADD:  begin {m_hi, m_lo} = acc + sp; lat = 2; end
      F_MADDU: begin {m_hi, m_lo} = acc + up; lat = 2; end
      F_MSUB:  begin {m_hi, m_lo} = acc - sp; lat = 2; end
      F_MSUBU: begin {m_hi, m_lo} = acc - up; lat = 2; end
      F_DIV, F_DIVU: begin
        s  = (f == F_DIV);
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (mb == 0) begin qq = 32'hFFFF_FFFF; rr = ma; end
        else begin qq = ma / mb; rr = ma % mb; end
        if (s && (a[31] ^ b[31])) qq = -qq;
        if (s && a[31]) rr = -rr;
        m_lo = qq; m_hi = rr; lat = 34;
      end
      F_MFHI: begin d = m_hi; w = 1'b1; end
      F_MFLO: begin d = m_lo; w = 1'b1; end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input logic [32:0] want);
    int w;
    exp_t e;
    logic [31:0] d;
    logic we;
    int lat;
    in_valid = 1'b1; in_funct = f; in_op_a = a; in_op_b = b; in_tag = next_tag;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("issue_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      model(f, a, b, d, we, lat);
      e.data = want[32] ? want[31:0] : d;
      e.wen = we; e.tag = next_tag; e.acc = cyc + 1; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    next_tag = next_tag + 1'b1;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [32:0] want_v(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = ($urandom_range(3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          check("out_data", 64'(out_data), 64'(q[0].data));
          check("out_wen", 64'(out_wen), 64'(q[0].wen));
          check("out_tag", 64'(out_tag), 64'(q[0].tag));
          void'(q.pop_front());
          seen = 1'b0;
        end else begin
          check("hold_data", 64'(out_data), 64'(q[0].data));
          check("hold_tag", 64'(out_tag), 64'(q[0].tag));
          check("hold_in_ready", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  logic [5:0] fl[14] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI,
                         F_MTLO, F_MUL, F_MADD, F_MADDU, F_MSUB, F_MSUBU, 6'h3F};
  logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] rand_op();
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_wen", 64'(out_wen), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(F_MFHI, 0, 0, 1, want_v(32'h0));
    issue(F_MFLO, 0, 0, 1, want_v(32'h0));

    issue(F_MULT, 32'hFFFF_FFFF, 32'd2, 1, NOWANT);
    issue(F_MFHI, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFE));
    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2, 1, NOWANT);
    issue(F_MFHI, 0, 0, 1, want_v(32'h1));
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFE));

    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1, NOWANT);
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFD));
    issue(F_MFHI, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_DIVU, 32'd7, 32'd0, 1, NOWANT);
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_MFHI, 0, 0, 1, want_v(32'h7));
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, NOWANT);
    issue(F_MFLO, 0, 0, 1, want_v(32'h8000_0000));
    issue(F_MFHI, 0, 0, 1, want_v(32'h0));

    issue(F_MTHI, 32'h0, 0, 1, NOWANT);
    issue(F_MTLO, 32'h5, 0, 1, NOWANT);
    issue(F_MADD, 32'd3, 32'd4, 1, NOWANT);
    issue(F_MFHI, 0, 0, 1, want_v(32'h0));
    issue(F_MFLO, 0, 0, 1, want_v(32'h11));
    issue(F_MSUBU, 32'd1, 32'h12, 1, NOWANT);
    issue(F_MFHI, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_MUL, 32'hFFFF_FFFD, 32'd5, 1, want_v(32'hFFFF_FFF1));
    issue(F_MFHI, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(F_MFLO, 0, 0, 1, want_v(32'hFFFF_FFFF));
    issue(6'h3F, 32'h1234, 32'h5678, 1, want_v(32'h0));
    drain();

    // Back-to-back moves: the MFLO is accepted on the MTLO handshake edge.
    issue(F_MTHI, 32'h0BAD_F00D, 0, 1, NOWANT);
    issue(F_MTLO, 32'h1234, 0, 1, NOWANT);
    issue(F_MFLO, 0, 0, 1, want_v(32'h1234));
    drain();

    // Flush in the middle of a divide: no result, HI/LO untouched.
    issue(F_DIV, 32'd100, 32'd7, 0, NOWANT);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    issue(F_MFHI, 0, 0, 1, want_v(32'h0BAD_F00D));
    issue(F_MFLO, 0, 0, 1, want_v(32'h1234));
    drain();

    // Consumer stalls: DONE must hold its result and refuse new work.
    rdy_mode = 2;
    issue(F_MULTU, 32'd6, 32'd7, 1, NOWANT);
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    drain();
    issue(F_MFLO, 0, 0, 1, want_v(32'd42));
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(fl[$urandom_range(13)], rand_op(), rand_op(), 1, NOWANT);
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 1;
    drain();
    issue(F_MFHI, 0, 0, 1, NOWANT);
    issue(F_MFLO, 0, 0, 1, NOWANT);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multiply/divide execution unit that consumes the decoded `funct` code and source operands issued from the ID/issue side and returns a tagged result to the write-back/commit side. It owns the architectural HI/LO registers and serialises every HI/LO-related operation. It is the function unit that executes the MULT/DIV/MADD/MSUB/MUL and HI/LO-move encodings produced by ID funct generation.

## Interface
Parameters:
- `TAG_WIDTH`, 6: width of the ROB tag carried with each operation.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset (0 = reset).
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  issue side presents an operation.
- `in_ready`  out  1  unit accepts the operation this cycle.
- `in_funct`  in  `FUNCT_BUS` (6)  `FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO`, `FUNCT2_MUL/MADD/MADDU/MSUB/MSUBU`.
- `in_op_a`, `in_op_b`  in  32 each  rs and rt values.
- `in_tag`  in  `TAG_WIDTH`  ROB tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  32  GPR result (MUL, MFHI, MFLO); 0 otherwise.
- `out_wen`  out  1  1 if `out_data` is to be written to a GPR.
- `out_tag`  out  `TAG_WIDTH`  tag of the completing operation.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. Accept = `in_valid & in_ready`; `in_ready = (state==IDLE) | (state==DONE & out_ready)`; accept latches funct, operands and tag.
- Dispatch on accept: MULT/MULTU/MUL/MADD*/MSUB* -> MUL; DIV/DIVU -> DIV; MFHI/MFLO/MTHI/MTLO and any other funct -> DONE directly.
- MUL (1 cycle): 64-bit product, signed for MULT/MUL/MADD/MSUB, unsigned otherwise. MADD*: {HI,LO}+prod; MSUB*: {HI,LO}-prod; both mod 2^64. MUL: `out_data` = product[31:0], `out_wen`=1, HI/LO untouched.
- DIV: restoring radix-2 on magnitudes (DIV takes abs of operands), 32 iteration cycles with 5-bit counter, then FIX (1 cycle) applies signs: quotient negated if signs differ, remainder takes dividend sign. LO=quotient, HI=remainder.
- Divide by zero: quotient 0xFFFFFFFF (magnitude), remainder = dividend magnitude, signs applied as above; no exception. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO write op_a to HI/LO; MFHI/MFLO return HI/LO with `out_wen`=1. Unknown funct: `out_wen`=0, no HI/LO change.
- HI/LO commit on the output handshake (`out_valid & out_ready`) only. Issue logic dispatches HI/LO writers to this unit only when non-speculative (ROB head).
- Forwarding: an MFHI/MFLO accepted in the same cycle as a HI/LO-writing handshake returns the newly written value.
- `flush`: highest priority; next state IDLE, `out_valid` 0, pending HI/LO update discarded, `in_valid` ignored that cycle.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_wen`=0, `out_tag`=0, HI=LO=0. Reset mid-divide aborts with no HI/LO change.
- Latency from accept edge T to `out_valid` high: moves/unknown T+1; multiply class T+2; divide T+34 (DIV T+1..T+32, FIX T+33, DONE T+34).
- DONE holds `out_*` stable until `out_ready`; with a new accept on the handshake edge, back-to-back moves give one result per cycle.
- Only one operation in flight; `in_ready`=0 in MUL, DIV, FIX, and DONE without `out_ready`.

## Test plan
- Reset then MULT a=0xFFFFFFFF, b=2 -> out_valid at T+2, out_wen=0; after handshake MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFE; MULTU same operands -> HI=1, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> out_valid exactly 34 cycles after accept; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- MTHI 0, MTLO 5, MADD a=3,b=4 -> {HI,LO}=0x0000_0000_0000_0011; MSUBU a=1,b=0x12 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF.
- MTLO 0x1234 handshake with out_ready=1 and MFLO accepted same edge -> MFLO out_data=0x1234 at T+1, one result per cycle.
- Flush at cycle 10 of a DIV -> out_valid never rises for it, in_ready=1 next cycle, HI/LO unchanged; out_ready held low in DONE -> out_data/out_tag stable, in_ready=0.
